cc_read_scheduler: RTL and testbench

Front-end scheduler for the cache controller read path: accepts one tag-lookup result per handshake, records the hit/miss order in the reorder unit's hit-flag FIFO, pushes hit lines into the hit-data FIFO, and issues one 8-beat AXI read burst to memory per miss. It sits between the tag/data lookup stage and the data reorder unit. It applies backpressure to the lookup stage in three cases: either reorder FIFO is almost full, an AR is still pending, or the outstanding-miss limit is reached.

---
 rtl/cc_read_scheduler.sv | 130 +++++++++++++
 tb/tb_cc_read_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_read_scheduler.sv
// cc_read_scheduler
// Front-end scheduler for the cache controller read path. It accepts one
// tag-lookup result per valid/ready handshake and records the hit/miss order
// in the reorder unit's hit-flag FIFO. Hit lines are pushed into the hit-data
// FIFO. Each miss issues one 8-beat AXI INCR read burst.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   lookup_*                 lookup result handshake (valid/ready, hit, addr, data)
//   hit_flag_fifo_*          flag FIFO almost-full input, write strobe/data outputs
//   hit_data_fifo_*          data FIFO almost-full input, write strobe/data outputs
//   mem_ar*                  AXI read address channel (master side)
//   mem_rvalid/rready/rlast  monitored AXI R channel, used to retire misses
//   outstanding_o            number of misses whose last R beat is still due
module cc_read_scheduler #(
  parameter int ADDR_W          = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  lookup_valid_i,
  output logic                                  lookup_ready_o,
  input  logic                                  lookup_hit_i,
  input  logic [ADDR_W-1:0]                     lookup_addr_i,
  input  logic [517:0]                          lookup_data_i,
  input  logic                                  hit_flag_fifo_afull_i,
  output logic                                  hit_flag_fifo_wren_o,
  output logic                                  hit_flag_fifo_wdata_o,
  input  logic                                  hit_data_fifo_afull_i,
  output logic                                  hit_data_fifo_wren_o,
  output logic [517:0]                          hit_data_fifo_wdata_o,
  output logic [ADDR_W-1:0]                     mem_araddr_o,
  output logic [3:0]                            mem_arlen_o,
  output logic [2:0]                            mem_arsize_o,
  output logic [1:0]                            mem_arburst_o,
  output logic                                  mem_arvalid_o,
  input  logic                                  mem_arready_i,
  input  logic                                  mem_rvalid_i,
  input  logic                                  mem_rready_i,
  input  logic                                  mem_rlast_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding_o
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {
    IDLE,
    AR_WAIT
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [ADDR_W-1:0]  r_araddr;
  logic [OUT_W-1:0]   r_outstanding;

  logic w_ready;
  logic w_accept;
  logic w_missAccept;
  logic w_completion;
  logic w_inc;
  logic w_dec;

  // Ready is a pure function of state, FIFO levels, the hit bit and the
  // miss budget. Valid does not gate it. Ready is forced low while reset is
  // held so that nothing is accepted into the FIFOs during reset.
  always_comb begin
    w_nextState = r_state;
    w_ready     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!rst) begin
          w_ready = !hit_flag_fifo_afull_i &&
                    (lookup_hit_i ? !hit_data_fifo_afull_i
                                  : (r_outstanding < OUT_W'(MAX_OUTSTANDING)));
        end
        if (lookup_valid_i && w_ready && !lookup_hit_i) begin
          w_nextState = AR_WAIT;
        end
      end
      AR_WAIT: begin
        if (mem_arready_i) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign w_accept     = lookup_valid_i && w_ready;
  assign w_missAccept = w_accept && !lookup_hit_i;
  assign w_completion = mem_rvalid_i && mem_rready_i && mem_rlast_i;
  assign w_inc        = w_missAccept;
  // A completion with nothing outstanding is stray and must not underflow.
  assign w_dec        = w_completion && (r_outstanding != '0);

  // State register, the latched miss address and the outstanding counter.
  // The slot is reserved at miss accept, so a simultaneous accept and
  // completion cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_araddr      <= '0;
      r_outstanding <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_missAccept) begin
        r_araddr <= lookup_addr_i & ~ADDR_W'(63);
      end
      case ({w_inc, w_dec})
        2'b10:   r_outstanding <= r_outstanding + OUT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - OUT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign lookup_ready_o        = w_ready;
  assign hit_flag_fifo_wren_o  = w_accept;
  assign hit_flag_fifo_wdata_o = lookup_hit_i;
  assign hit_data_fifo_wren_o  = w_accept && lookup_hit_i;
  assign hit_data_fifo_wdata_o = lookup_data_i;

  assign mem_araddr_o  = r_araddr;
  assign mem_arvalid_o = (r_state == AR_WAIT);
  assign mem_arlen_o   = 4'd7;
  assign mem_arsize_o  = 3'b011;
  assign mem_arburst_o = 2'b01;
  assign outstanding_o = r_outstanding;

endmodule

// File: tb/tb_cc_read_scheduler.sv
// tb_cc_read_scheduler
// Self-checking bench for cc_read_scheduler. A table of per-cycle vectors
// drives the scheduler through hits, misses, backpressure and the R-channel
// completions. Hand-written sequences cover reset during AR_WAIT and an
// AR handshake with a random delay. FIFO writes and AR handshakes are
// matched against scoreboard queues filled when the stimulus is driven.
module tb_cc_read_scheduler;

  logic         clk;
  logic         rst;
  logic         lookup_valid_i;
  logic         lookup_ready_o;
  logic         lookup_hit_i;
  logic [31:0]  lookup_addr_i;
  logic [517:0] lookup_data_i;
  logic         hit_flag_fifo_afull_i;
  logic         hit_flag_fifo_wren_o;
  logic         hit_flag_fifo_wdata_o;
  logic         hit_data_fifo_afull_i;
  logic         hit_data_fifo_wren_o;
  logic [517:0] hit_data_fifo_wdata_o;
  logic [31:0]  mem_araddr_o;
  logic [3:0]   mem_arlen_o;
  logic [2:0]   mem_arsize_o;
  logic [1:0]   mem_arburst_o;
  logic         mem_arvalid_o;
  logic         mem_arready_i;
  logic         mem_rvalid_i;
  logic         mem_rready_i;
  logic         mem_rlast_i;
  logic [1:0]   outstanding_o;

  int total = 0;
  int bad   = 0;

  logic         flagQ[$];
  logic [517:0] dataQ[$];
  logic [31:0]  arQ[$];
  logic [31:0]  modelAraddr = '0;

  cc_read_scheduler #(.ADDR_W(32), .MAX_OUTSTANDING(2)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .lookup_valid_i        (lookup_valid_i),
    .lookup_ready_o        (lookup_ready_o),
    .lookup_hit_i          (lookup_hit_i),
    .lookup_addr_i         (lookup_addr_i),
    .lookup_data_i         (lookup_data_i),
    .hit_flag_fifo_afull_i (hit_flag_fifo_afull_i),
    .hit_flag_fifo_wren_o  (hit_flag_fifo_wren_o),
    .hit_flag_fifo_wdata_o (hit_flag_fifo_wdata_o),
    .hit_data_fifo_afull_i (hit_data_fifo_afull_i),
    .hit_data_fifo_wren_o  (hit_data_fifo_wren_o),
    .hit_data_fifo_wdata_o (hit_data_fifo_wdata_o),
    .mem_araddr_o          (mem_araddr_o),
    .mem_arlen_o           (mem_arlen_o),
    .mem_arsize_o          (mem_arsize_o),
    .mem_arburst_o         (mem_arburst_o),
    .mem_arvalid_o         (mem_arvalid_o),
    .mem_arready_i         (mem_arready_i),
    .mem_rvalid_i          (mem_rvalid_i),
    .mem_rready_i          (mem_rready_i),
    .mem_rlast_i           (mem_rlast_i),
    .outstanding_o         (outstanding_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         valid;
    logic         hit;
    logic         hAfull;
    logic         fAfull;
    logic         arready;
    logic         rlast;
    logic [31:0]  addr;
    logic [517:0] data;
    logic         expReady;
    logic         expFlagWr;
    logic         expDataWr;
    logic         expArvalid;
    logic [1:0]   expOut;
  } vec_t;

  vec_t vecs[$];

  // Compares one value and counts it; a mismatch prints one FAIL line.
  task automatic checkOutput(input string name, input logic [517:0] actual,
                             input logic [517:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", name, actual, expected);
    end
  endtask

  task automatic addVec(input logic v, h, ha, fa, arr, rl,
                        input logic [31:0] a, input logic [517:0] d,
                        input logic eR, eF, eD, eA, input logic [1:0] eO);
    vec_t x;
    x.valid = v; x.hit = h; x.hAfull = ha; x.fAfull = fa; x.arready = arr;
    x.rlast = rl; x.addr = a; x.data = d; x.expReady = eR; x.expFlagWr = eF;
    x.expDataWr = eD; x.expArvalid = eA; x.expOut = eO;
    vecs.push_back(x);
  endtask

  // Waits past the active edge, drives a full set of inputs, and records the
  // expected scoreboard entries for any accept the caller predicts.
  task automatic applyStimulus(input logic v, h, ha, fa, arr, rl,
                               input logic [31:0] a, input logic [517:0] d,
                               input logic expAccept);
    @(posedge clk);
    #1;
    lookup_valid_i        = v;
    lookup_hit_i          = h;
    hit_data_fifo_afull_i = ha;
    hit_flag_fifo_afull_i = fa;
    mem_arready_i         = arr;
    mem_rvalid_i          = rl;
    mem_rlast_i           = rl;
    lookup_addr_i         = a;
    lookup_data_i         = d;
    if (expAccept) begin
      flagQ.push_back(h);
      if (h) dataQ.push_back(d);
      else begin
        modelAraddr = a & 32'hFFFF_FFC0;
        arQ.push_back(modelAraddr);
      end
    end
  endtask

  // Scoreboard monitor: every observed write or AR handshake must match the
  // oldest expected entry.
  always @(negedge clk) begin
    if (hit_flag_fifo_wren_o) begin
      if (flagQ.size() == 0) checkOutput("sb.flag_unexpected", 1, 0);
      else checkOutput("sb.flag", hit_flag_fifo_wdata_o, flagQ.pop_front());
    end
    if (hit_data_fifo_wren_o) begin
      if (dataQ.size() == 0) checkOutput("sb.data_unexpected", 1, 0);
      else checkOutput("sb.data", hit_data_fifo_wdata_o, dataQ.pop_front());
    end
    if (mem_arvalid_o && mem_arready_i) begin
      if (arQ.size() == 0) checkOutput("sb.ar_unexpected", 1, 0);
      else checkOutput("sb.araddr", mem_araddr_o, arQ.pop_front());
    end
  end

  initial begin
    bit arDone;
    int delay;

    // Cycle-by-cycle table: v h hAf fAf arr rlast addr data | ready flagWr dataWr arvalid out
    addVec(1,1,0,0,0,0, 32'h0, 518'h1, 1,1,1,0,0);
    addVec(1,1,0,0,0,0, 32'h0, 518'h2, 1,1,1,0,0);
    addVec(1,1,0,0,0,0, 32'h0, 518'h3, 1,1,1,0,0);
    addVec(1,1,0,0,0,0, 32'h0, 518'h4, 1,1,1,0,0);
    addVec(1,0,0,0,0,0, 32'h0000_1234, 518'h0, 1,1,0,0,0);
    addVec(1,1,0,0,0,0, 32'h0, 518'h5, 0,0,0,1,1);
    addVec(1,1,0,0,0,0, 32'h0, 518'h5, 0,0,0,1,1);
    addVec(1,1,0,0,1,0, 32'h0, 518'h5, 0,0,0,1,1);
    addVec(1,1,0,0,0,0, 32'h0, 518'h5, 1,1,1,0,1);
    addVec(1,1,1,0,0,0, 32'h0, 518'h6, 0,0,0,0,1);
    addVec(1,0,1,0,0,0, 32'h0000_2040, 518'h0, 1,1,0,0,1);
    addVec(0,0,0,0,1,0, 32'h0, 518'h0, 0,0,0,1,2);
    addVec(1,0,0,0,0,0, 32'h0000_3000, 518'h0, 0,0,0,0,2);
    addVec(1,0,0,0,0,1, 32'h0000_3000, 518'h0, 0,0,0,0,2);
    addVec(1,0,0,0,0,0, 32'h0000_3000, 518'h0, 1,1,0,0,1);
    addVec(0,0,0,0,1,1, 32'h0, 518'h0, 0,0,0,1,2);
    addVec(1,0,0,0,0,1, 32'h0000_4444, 518'h0, 1,1,0,0,1);
    addVec(0,0,0,0,1,0, 32'h0, 518'h0, 0,0,0,1,1);
    addVec(0,0,0,0,0,1, 32'h0, 518'h0, 1,0,0,0,1);
    addVec(0,0,0,0,0,1, 32'h0, 518'h0, 1,0,0,0,0);
    addVec(0,0,0,0,0,0, 32'h0, 518'h0, 1,0,0,0,0);
    addVec(1,1,0,1,0,0, 32'h0, 518'h9, 0,0,0,0,0);
    addVec(1,0,0,1,0,0, 32'h0000_5555, 518'h0, 0,0,0,0,0);
    addVec(1,1,0,0,0,0, 32'h0, 518'h7, 1,1,1,0,0);

    rst = 1'b1;
    lookup_valid_i = 1'b1; lookup_hit_i = 1'b0; lookup_addr_i = '0;
    lookup_data_i = '0; hit_flag_fifo_afull_i = 1'b0; hit_data_fifo_afull_i = 1'b0;
    mem_arready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rready_i = 1'b1; mem_rlast_i = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.ready", lookup_ready_o, 0);
    checkOutput("reset.flag_wren", hit_flag_fifo_wren_o, 0);
    checkOutput("reset.arvalid", mem_arvalid_o, 0);
    checkOutput("reset.araddr", mem_araddr_o, 0);
    checkOutput("reset.outstanding", outstanding_o, 0);
    checkOutput("const.arlen", mem_arlen_o, 4'd7);
    checkOutput("const.arsize", mem_arsize_o, 3'b011);
    checkOutput("const.arburst", mem_arburst_o, 2'b01);
    @(posedge clk);
    #1;
    rst = 1'b0;
    lookup_valid_i = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].valid, vecs[i].hit, vecs[i].hAfull, vecs[i].fAfull,
                    vecs[i].arready, vecs[i].rlast, vecs[i].addr, vecs[i].data,
                    vecs[i].expFlagWr);
      @(negedge clk);
      checkOutput($sformatf("v%0d.ready", i), lookup_ready_o, vecs[i].expReady);
      checkOutput($sformatf("v%0d.flag_wren", i), hit_flag_fifo_wren_o, vecs[i].expFlagWr);
      if (vecs[i].expFlagWr)
        checkOutput($sformatf("v%0d.flag_wdata", i), hit_flag_fifo_wdata_o, vecs[i].hit);
      checkOutput($sformatf("v%0d.data_wren", i), hit_data_fifo_wren_o, vecs[i].expDataWr);
      checkOutput($sformatf("v%0d.arvalid", i), mem_arvalid_o, vecs[i].expArvalid);
      checkOutput($sformatf("v%0d.outstanding", i), outstanding_o, vecs[i].expOut);
      if (vecs[i].expArvalid)
        checkOutput($sformatf("v%0d.araddr", i), mem_araddr_o, modelAraddr);
    end

    // Reset while an AR is pending: the AR is dropped and a hit goes straight in.
    applyStimulus(1,0,0,0,0,0, 32'h0000_5000, 518'h0, 1);
    void'(arQ.pop_back());
    @(negedge clk);
    checkOutput("rstseq.miss_accept", hit_flag_fifo_wren_o, 1);
    applyStimulus(0,0,0,0,0,0, 32'h0, 518'h0, 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstseq.arvalid_pending", mem_arvalid_o, 1);
    checkOutput("rstseq.ready_in_reset", lookup_ready_o, 0);
    applyStimulus(1,1,0,0,0,0, 32'h0, 518'h8, 1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstseq.arvalid_dropped", mem_arvalid_o, 0);
    checkOutput("rstseq.outstanding", outstanding_o, 0);
    checkOutput("rstseq.araddr", mem_araddr_o, 0);
    checkOutput("rstseq.hit_ready", lookup_ready_o, 1);
    checkOutput("rstseq.hit_data_wren", hit_data_fifo_wren_o, 1);

    // Miss whose AR is accepted after a random delay, with a bounded wait.
    applyStimulus(1,0,0,0,0,0, 32'hABCD_EF7F, 518'h0, 1);
    @(negedge clk);
    checkOutput("late.accept", hit_flag_fifo_wren_o, 1);
    delay  = $urandom_range(1, 3);
    arDone = 1'b0;
    for (int k = 0; k < 10 && !arDone; k++) begin
      applyStimulus(0,0,0,0, (k >= delay), 0, 32'h0, 518'h0, 0);
      @(negedge clk);
      if (mem_arvalid_o && mem_arready_i) arDone = 1'b1;
    end
    checkOutput("late.ar_handshake_seen", arDone, 1);
    applyStimulus(0,0,0,0,0,1, 32'h0, 518'h0, 0);
    @(negedge clk);
    checkOutput("late.back_idle", mem_arvalid_o, 0);
    checkOutput("late.outstanding", outstanding_o, 1);

    checkOutput("end.flagQ_empty", flagQ.size(), 0);
    checkOutput("end.dataQ_empty", dataQ.size(), 0);
    checkOutput("end.arQ_empty", arQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
